ex_muldiv_ctrl: RTL and testbench



---
 rtl/mips_ex_pkg.sv | 23 ++
 rtl/ex_muldiv_iter.sv | 49 ++++
 rtl/ex_muldiv_ctrl.sv | 121 ++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ex_pkg.sv
// rtl/mips_ex_pkg.sv - shared op codes, FSM encoding and widths for the EX mul/div unit
package mips_ex_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FIXUP = 2'd2
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_iter.sv
// rtl/ex_muldiv_iter.sv - one unsigned shift-add / restoring-subtract step per cycle
module ex_muldiv_iter import mips_ex_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_raw,
    output logic [WIDTH-1:0] lo_raw
);

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               div_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc   <= {{WIDTH{1'b0}}, a};
            opb   <= b;
            div_q <= is_div;
        end else if (step) begin
            if (div_q) begin
                if (!div_diff[WIDTH])
                    acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end
    end

    assign hi_raw = acc[2*WIDTH-1:WIDTH];
    assign lo_raw = acc[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - HI/LO owner: mul/div sequencing, sign fixup, MF/MT and pipeline stall
module ex_muldiv_ctrl import mips_ex_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result
);

    md_state_t          state, state_nx;
    logic [CNT_W-1:0]   counter;
    logic               is_md, is_hilo, signed_op, accept, rs_neg, rt_neg, mt_ok;
    logic               neg_lo_q, neg_hi_q, div0_q, op_div_q;
    logic [WIDTH-1:0]   rs_q, a_mag, b_mag, hi_raw, lo_raw, hi_fix, lo_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_md     = (op >= MD_MULT) && (op <= MD_DIVU);
    assign is_hilo   = (op >= MD_MULT) && (op <= MD_MTLO);
    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign rs_neg    = signed_op && rs_val[WIDTH-1];
    assign rt_neg    = signed_op && rt_val[WIDTH-1];
    assign a_mag     = rs_neg ? -rs_val : rs_val;
    assign b_mag     = rt_neg ? -rt_val : rt_val;
    assign accept    = start && !flush && is_md && (state == ST_IDLE);
    assign mt_ok     = start && !flush && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign stall     = start && is_hilo && busy;
    assign done      = (state == ST_FIXUP) && !flush;

    always_comb begin
        mf_result = '0;
        if (op == MD_MFHI)
            mf_result = hi;
        else if (op == MD_MFLO)
            mf_result = lo;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_BUSY;
            ST_BUSY:  if (flush) state_nx = ST_IDLE;
                      else if (counter == CNT_W'(WIDTH-1)) state_nx = ST_FIXUP;
            ST_FIXUP: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Divide by zero ignores signs: quotient all ones, remainder is the raw dividend
    always_comb begin
        prod_fix = {hi_raw, lo_raw};
        if (neg_lo_q)
            prod_fix = -prod_fix;
        lo_fix = neg_lo_q ? -lo_raw : lo_raw;
        hi_fix = neg_hi_q ? -hi_raw : hi_raw;
        if (!op_div_q) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
            hi_fix = rs_q;
            lo_fix = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            counter  <= '0;
            hi       <= '0;
            lo       <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            op_div_q <= 1'b0;
            rs_q     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                counter  <= '0;
                op_div_q <= (op == MD_DIV) || (op == MD_DIVU);
                neg_lo_q <= rs_neg ^ rt_neg;
                neg_hi_q <= rs_neg;
                div0_q   <= (rt_val == '0);
                rs_q     <= rs_val;
            end else if (state == ST_BUSY) begin
                counter <= counter + 1'b1;
            end
            if (done) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end else if (mt_ok && op == MD_MTHI) begin
                hi <= rs_val;
            end else if (mt_ok && op == MD_MTLO) begin
                lo <= rs_val;
            end
        end
    end

    ex_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .load   (accept),
        .step   (state == ST_BUSY),
        .is_div ((op == MD_DIV) || (op == MD_DIVU)),
        .a      (a_mag),
        .b      (b_mag),
        .hi_raw (hi_raw),
        .lo_raw (lo_raw)
    );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb/tb_ex_muldiv_ctrl.sv - scoreboard bench for the EX mul/div sequencer
module tb_ex_muldiv_ctrl;
    import mips_ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        stall, busy, done;
    logic [31:0] hi, lo, mf_result;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
        .done(done), .hi(hi), .lo(lo), .mf_result(mf_result)
    );

    task automatic drive(input logic s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = s; op = o; rs_val = a; rt_val = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; drive(1'b0, MD_NONE, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, stall} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0 || mf_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b stall=%b hi=%h lo=%h mf=%h want all zero", busy, done, stall, hi, lo, mf_result);
        end
    endtask

    // Issue one mul/div, check latency and busy width, then compare HI/LO against the scoreboard
    task automatic run_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        int cyc = 0;
        int busy_cyc = 0;
        bit seen = 0;
        logic [63:0] want;
        sb.push_back(exp);
        @(posedge clk); #1 drive(1'b1, o, a, b);
        @(posedge clk); #1 drive(1'b0, MD_NONE, 32'h0, 32'h0);
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (done) seen = 1;
        end
        vectors++;
        if (!seen || cyc != 33 || busy_cyc != 33) begin
            miscompares++;
            $display("FAIL %s latency: done_cycle=%0d busy_cycles=%0d seen=%0d want 33/33/1", name, cyc, busy_cyc, seen);
        end
        @(posedge clk); #1;
        want = sb.pop_front();
        vectors++;
        if ({hi, lo} !== want || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s result: hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", name, hi, lo, busy, want[63:32], want[31:0]);
        end
    endtask

    task automatic test_mul_div();
        run_md(MD_MULTU, 32'd7, 32'd6, {32'h0, 32'd42}, "multu_7x6");
        run_md(MD_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, "mult_m2x3");
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        run_md(MD_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "divu_by_zero");
        run_md(MD_DIV, 32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFF8, 32'hFFFF_FFFF}, "div_by_zero");
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_overflow");
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic [31:0] a, b;
        logic signed [31:0] sa, sb_;
        logic [63:0] exp;
        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(1, 4));
            a = $urandom;
            b = $urandom;
            if (i < 4) a = a >> $urandom_range(0, 31);
            if (o == MD_DIV || o == MD_DIVU) begin
                if (b == 32'h0) b = 32'd3;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'd1;
            end
            sa = a; sb_ = b;
            case (o)
                MD_MULTU: exp = {32'h0, a} * {32'h0, b};
                MD_MULT:  exp = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
                MD_DIVU:  exp = {a % b, a / b};
                default:  exp = {32'(sa % sb_), 32'(sa / sb_)};
            endcase
            run_md(o, a, b, exp, "random");
        end
    endtask

    task automatic test_mf_stall();
        int st_cnt = 0;
        sb.push_back({32'h0, 32'd12});
        @(posedge clk); #1 drive(1'b1, MD_MULTU, 32'd3, 32'd4);
        @(posedge clk); #1 drive(1'b1, MD_MFLO, 32'h0, 32'h0);
        while (st_cnt < 40) begin
            @(negedge clk);
            if (!stall) break;
            st_cnt++;
        end
        vectors++;
        if (st_cnt != 33 || mf_result !== sb[0][31:0]) begin
            miscompares++;
            $display("FAIL mflo_stall: stall_cycles=%0d mf=%h want 33 and %h", st_cnt, mf_result, sb[0][31:0]);
        end
        void'(sb.pop_front());
        @(posedge clk); #1 drive(1'b0, MD_NONE, 32'h0, 32'h0);
    endtask

    task automatic test_mt();
        int st_cnt = 0;
        @(posedge clk); #1 drive(1'b1, MD_MTHI, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_stall: stall=%b want 0", stall);
        end
        @(posedge clk); #1 drive(1'b1, MD_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        vectors++;
        if (mf_result !== 32'hDEAD_BEEF || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL mfhi_after_mthi: mf=%h stall=%b want deadbeef 0", mf_result, stall);
        end
        // MTLO presented while a multiply runs must wait and land after it
        @(posedge clk); #1 drive(1'b1, MD_MULTU, 32'd2, 32'd5);
        @(posedge clk); #1 drive(1'b1, MD_MTLO, 32'h0000_1234, 32'h0);
        while (st_cnt < 40) begin
            @(negedge clk);
            if (!stall) break;
            st_cnt++;
        end
        vectors++;
        if (st_cnt != 33 || lo !== 32'd10) begin
            miscompares++;
            $display("FAIL mtlo_busy_stall: stall_cycles=%0d lo=%h want 33 and 0000000a", st_cnt, lo);
        end
        @(posedge clk); #1 drive(1'b0, MD_NONE, 32'h0, 32'h0);
        vectors++;
        if (lo !== 32'h0000_1234 || hi !== 32'h0) begin
            miscompares++;
            $display("FAIL mtlo_write: hi=%h lo=%h want 00000000 00001234", hi, lo);
        end
    endtask

    task automatic test_ignored();
        @(posedge clk); #1 drive(1'b1, 4'hF, 32'h1, 32'h1);
        @(posedge clk); #1 drive(1'b1, MD_NONE, 32'h1, 32'h1);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || mf_result !== 32'h0) begin
            miscompares++;
            $display("FAIL ignored_op: busy=%b mf=%h want 0 0", busy, mf_result);
        end
        @(posedge clk); #1 drive(1'b1, MD_MTHI, 32'h5555_AAAA, 32'h0); flush = 1'b1;
        @(posedge clk); #1 drive(1'b0, MD_NONE, 32'h0, 32'h0); flush = 1'b0;
        vectors++;
        if (hi !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_blocks_start: hi=%h want 00000000", hi);
        end
    endtask

    task automatic test_flush();
        int dn = 0;
        @(posedge clk); #1 drive(1'b1, MD_DIVU, 32'd100, 32'd7);
        @(posedge clk); #1 drive(1'b0, MD_NONE, 32'h0, 32'h0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL flush: busy=%b hi=%h lo=%h want 0 00000000 00001234", busy, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        vectors++;
        if (dn != 0 || lo !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL flush_no_done: done_pulses=%0d lo=%h want 0 00001234", dn, lo);
        end
    endtask

    task automatic test_rst_mid();
        @(posedge clk); #1 drive(1'b1, MD_DIV, 32'd1000, 32'd3);
        @(posedge clk); #1 drive(1'b0, MD_NONE, 32'h0, 32'h0);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_after_rst");
    endtask

    initial begin
        test_reset();
        test_mul_div();
        test_random();
        test_mf_stall();
        test_mt();
        test_ignored();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
